// File: rtl/dct_transpose_buf_pkg.sv
// Shared 2D-DCT definitions: block geometry, coefficient widths and lane helpers.
// The row DCT, transpose buffer and column DCT stages all import this package.
package dct_transpose_buf_pkg;

    localparam int unsigned DCT_N     = 8;
    localparam int unsigned DCT_BW_1D = 11;
    localparam int unsigned DCT_BLK_W = 12;

    typedef enum logic {
        StIdle,
        StDrain
    } rd_state_e;

    // Lane 0 sits at the MSB end of a packed row/column vector.
    function automatic logic [DCT_BW_1D-1:0] lane(input logic [DCT_N*DCT_BW_1D-1:0] vec,
                                                  input int unsigned k);
        logic [DCT_N*DCT_BW_1D-1:0] w_sh;
        w_sh = vec >> (DCT_BW_1D * (DCT_N - 1 - k));
        return w_sh[DCT_BW_1D-1:0];
    endfunction

endpackage

// File: rtl/dct_tbuf_bank.sv
// One N x N coefficient bank: row-wide write port, combinational column read port.
// Contents are deliberately not reset.
module dct_tbuf_bank
    import dct_transpose_buf_pkg::*;
#(
    parameter int unsigned N  = DCT_N,
    parameter int unsigned BW = DCT_BW_1D,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_row,
    input  logic [N*BW-1:0] i_data,
    input  logic [AW-1:0]   i_col,
    output logic [N*BW-1:0] o_data
);

    logic [BW-1:0] r_mem [N][N];
    logic [BW-1:0] w_lanes [N];

    for (genvar j = 0; j < N; j++) begin : g_unpack
        assign w_lanes[j] = lane(i_data, j);
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int j = 0; j < N; j++) begin
                r_mem[i_row][j] <= w_lanes[j];
            end
        end
    end

    // Column read: output lane k is element (k, i_col).
    for (genvar k = 0; k < N; k++) begin : g_col
        assign o_data[BW*(N-k)-1 -: BW] = r_mem[k][i_col];
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rows in, columns out, one bank fills while the other drains.
// Fixed latency, no back-pressure; all outputs registered.
module dct_transpose_buf
    import dct_transpose_buf_pkg::*;
#(
    parameter int unsigned BW    = DCT_BW_1D,
    parameter int unsigned N     = DCT_N,
    parameter int unsigned BLK_W = DCT_BLK_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N*BW-1:0]  in_data,
    output logic             out_valid,
    output logic [N*BW-1:0]  out_data,
    output logic             out_first,
    output logic             out_last,
    output logic [BLK_W-1:0] out_blk
);

    localparam int unsigned AW = $clog2(N);

    logic [AW-1:0]    r_wr_row;
    logic             r_wr_bank;
    logic             r_evt;
    rd_state_e        r_state, w_state_d;
    logic             r_rd_bank, w_rd_bank_d;
    logic [AW-1:0]    r_rd_col, w_rd_col_d;
    logic             r_pend, w_pend_d;
    logic             w_emit;
    logic             w_wr_last;
    logic             w_col_last;
    logic [N*BW-1:0]  w_col0, w_col1, w_col;
    logic             r_out_valid, r_out_first, r_out_last;
    logic [N*BW-1:0]  r_out_data;
    logic [BLK_W-1:0] r_out_blk;

    assign w_wr_last  = (r_wr_row == AW'(N - 1));
    assign w_col_last = (r_rd_col == AW'(N - 1));
    assign w_col      = r_rd_bank ? w_col1 : w_col0;

    dct_tbuf_bank #(.N(N), .BW(BW), .AW(AW)) u_bank0 (
        .clk    (clk),
        .i_we   (in_valid && !r_wr_bank),
        .i_row  (r_wr_row),
        .i_data (in_data),
        .i_col  (r_rd_col),
        .o_data (w_col0)
    );

    dct_tbuf_bank #(.N(N), .BW(BW), .AW(AW)) u_bank1 (
        .clk    (clk),
        .i_we   (in_valid && r_wr_bank),
        .i_row  (r_wr_row),
        .i_data (in_data),
        .i_col  (r_rd_col),
        .o_data (w_col1)
    );

    // Read FSM: a bank-full event seen in idle emits column 0 right away, so back-to-back
    // blocks drain with no bubble.
    always_comb begin
        w_state_d   = r_state;
        w_rd_bank_d = r_rd_bank;
        w_rd_col_d  = r_rd_col;
        w_pend_d    = r_pend;
        w_emit      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_evt) begin
                    w_emit     = 1'b1;
                    w_rd_col_d = AW'(1);
                    w_state_d  = StDrain;
                end
            end
            StDrain: begin
                w_emit = 1'b1;
                if (w_col_last) begin
                    w_rd_col_d  = '0;
                    w_rd_bank_d = ~r_rd_bank;
                    w_pend_d    = 1'b0;
                    if (!(r_evt || r_pend)) begin
                        w_state_d = StIdle;
                    end
                end else begin
                    w_rd_col_d = r_rd_col + 1'b1;
                    w_pend_d   = r_pend || r_evt;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_row    <= '0;
            r_wr_bank   <= 1'b0;
            r_evt       <= 1'b0;
            r_state     <= StIdle;
            r_rd_bank   <= 1'b0;
            r_rd_col    <= '0;
            r_pend      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_blk   <= '0;
        end else begin
            if (in_valid) begin
                r_wr_row <= w_wr_last ? '0 : r_wr_row + 1'b1;
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            r_evt       <= in_valid && w_wr_last;
            r_state     <= w_state_d;
            r_rd_bank   <= w_rd_bank_d;
            r_rd_col    <= w_rd_col_d;
            r_pend      <= w_pend_d;
            r_out_valid <= w_emit;
            r_out_first <= w_emit && (r_rd_col == '0);
            r_out_last  <= w_emit && w_col_last;
            if (w_emit) begin
                r_out_data <= w_col;
            end
            if (r_out_last) begin
                r_out_blk <= r_out_blk + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;
    assign out_blk   = r_out_blk;

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Scoreboard bench for dct_transpose_buf: expected columns are queued as each block's last row
// is driven and compared, including arrival cycle, whenever out_valid is seen.
module tb_dct_transpose_buf;

    localparam int BW = 11;
    localparam int N  = 8;
    localparam int W  = N * BW;

    typedef struct {
        logic [W-1:0] data;
        logic         first;
        logic         last;
        logic [11:0]  blk;
        int           cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_first;
    logic          out_last;
    logic [11:0]   out_blk;

    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    exp_t          q[$];
    logic [BW-1:0] rows [N][N];
    int            wr = 0;
    logic [11:0]   blk_model = '0;

    dct_transpose_buf u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .out_blk   (out_blk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Drive one input cycle; a completed block queues its eight expected columns.
    task automatic send(input logic v, input logic [W-1:0] d);
        logic [W-1:0] col;
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        if (v) begin
            for (int k = 0; k < N; k++) rows[wr][k] = BW'(d >> (BW * (N - 1 - k)));
            if (wr == N - 1) begin
                for (int c = 0; c < N; c++) begin
                    exp_t e;
                    col = '0;
                    for (int k = 0; k < N; k++) col = (col << BW) | W'(rows[k][c]);
                    e.data  = col;
                    e.first = (c == 0);
                    e.last  = (c == N - 1);
                    e.blk   = blk_model;
                    e.cyc   = cyc + 2 + c;
                    q.push_back(e);
                end
                blk_model = blk_model + 1'b1;
                wr = 0;
            end else begin
                wr++;
            end
        end
    endtask

    function automatic logic [W-1:0] pack_row(input int r, input int mode);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            logic [BW-1:0] e;
            case (mode)
                0:       e = BW'(16 * r + k);
                1:       e = (r == 0) ? 11'h400 : (r == 1) ? 11'h3FF : 11'h000;
                default: e = BW'($urandom);
            endcase
            v = (v << BW) | W'(e);
        end
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, W'(out_valid), '0);
        check({tag, "_first"}, W'(out_first), '0);
        check({tag, "_last"},  W'(out_last),  '0);
        check({tag, "_data"},  out_data,      '0);
        check({tag, "_blk"},   W'(out_blk),   '0);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_col", W'(1), W'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("col_data",  out_data,       e.data);
                check("col_first", W'(out_first),  W'(e.first));
                check("col_last",  W'(out_last),   W'(e.last));
                check("col_blk",   W'(out_blk),    W'(e.blk));
                check("col_cycle", W'(cyc),        W'(e.cyc));
            end
        end
    end

    initial begin
        #2;
        check_reset_outputs("reset0");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Counting pattern: row r lane k = 16*r + k.
        for (int r = 0; r < N; r++) send(1'b1, pack_row(r, 0));
        idle(12);

        // Eight blocks back-to-back.
        for (int i = 0; i < 8 * N; i++) send(1'b1, pack_row(i % N, 2));
        idle(12);

        // in_valid toggling for one block.
        for (int r = 0; r < N; r++) begin
            send(1'b1, pack_row(r, 2));
            send(1'b0, '0);
        end
        idle(12);

        // Sign/width extremes.
        for (int r = 0; r < N; r++) send(1'b1, pack_row(r, 1));
        idle(12);

        // Reset after row 4 of block 2, with block 1 still draining.
        for (int i = 0; i < 2 * N + 5; i++) send(1'b1, pack_row(i % N, 2));
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        wr        = 0;
        blk_model = '0;
        #1;
        check_reset_outputs("reset_mid");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int r = 0; r < N; r++) send(1'b1, pack_row(r, 2));
        idle(12);

        // 4097 blocks back-to-back: out_blk wraps 4095 -> 0.
        for (int i = 0; i < 4097 * N; i++) send(1'b1, pack_row(i % N, 2));
        for (int i = 0; i < 20 && q.size() != 0; i++) send(1'b0, '0);
        idle(2);

        check("queue_empty", W'(q.size()), W'(0));
        check("final_blk", W'(out_blk), W'(blk_model));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
